// File: rtl/force_release_target.sv
// Forceable-signal responder: applies FORCE/RELEASE/READ commands over a source driver
// and presents the merged (forced-or-source) value to downstream consumers.
module force_release_target #(
    parameter int  WIDTH  = 64,
    parameter bit  IS_NET = 1'b0,
    localparam int IDX_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_we,
    input  logic [WIDTH-1:0] src_val,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [IDX_W-1:0] cmd_lsb,
    input  logic [IDX_W-1:0] cmd_msb,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [WIDTH-1:0] rsp_mask,
    output logic             rsp_err,
    output logic [WIDTH-1:0] value_out,
    output logic             force_active
);
    localparam logic [1:0] OP_FORCE   = 2'b01;
    localparam logic [1:0] OP_RELEASE = 2'b10;

    typedef enum logic [1:0] {IDLE, APPLY, RESP} state_t;
    state_t state, state_n;

    logic [1:0]       op_q;
    logic [IDX_W-1:0] lsb_q, msb_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] en, fval, var_q;
    logic [WIDTH-1:0] en_n, fval_n, var_n;
    logic [WIDTH-1:0] mask, hit, src_n, merged_n;
    logic             err;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (cmd_valid) state_n = APPLY;
            APPLY:   state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        mask = '0;
        for (int i = 0; i < WIDTH; i++)
            mask[i] = (i >= int'(lsb_q)) && (i <= int'(msb_q));
    end

    assign err = (op_q == 2'b00) || (msb_q < lsb_q) || (int'(msb_q) >= WIDTH);
    // Only bits that were actually forced hand their value back to the variable.
    assign hit = mask & en;

    always_comb begin
        en_n   = en;
        fval_n = fval;
        var_n  = var_q;
        if (state == APPLY && !err) begin
            case (op_q)
                OP_FORCE: begin
                    en_n   = en | mask;
                    fval_n = (fval & ~mask) | ((data_q << lsb_q) & mask);
                end
                OP_RELEASE: begin
                    en_n = en & ~mask;
                    if (!IS_NET) var_n = (var_q & ~hit) | (fval & hit);
                end
                default: ;
            endcase
        end
        // A same-cycle source write overrides any release hand-back.
        if (!IS_NET && src_we) var_n = src_val;
        src_n    = IS_NET ? src_val : var_n;
        merged_n = (en_n & fval_n) | (~en_n & src_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            lsb_q    <= '0;
            msb_q    <= '0;
            data_q   <= '0;
            en       <= '0;
            fval     <= '0;
            var_q    <= '0;
            rsp_data <= '0;
            rsp_mask <= '0;
            rsp_err  <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                op_q   <= cmd_op;
                lsb_q  <= cmd_lsb;
                msb_q  <= cmd_msb;
                data_q <= cmd_data;
            end
            en    <= en_n;
            fval  <= fval_n;
            var_q <= var_n;
            if (state == APPLY) begin
                rsp_data <= merged_n;
                rsp_mask <= en_n;
                rsp_err  <= err;
            end
        end
    end

    assign value_out    = (en & fval) | (~en & (IS_NET ? src_val : var_q));
    assign force_active = |en;
endmodule

// File: tb/tb_force_release_target.sv
// Bench for force_release_target: variable, net and non-power-of-two instances share one
// command bus; vector table with a response scoreboard plus hand-written corner sequences.
module tb_force_release_target;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, src_we, cmd_valid, rsp_ready;
    logic [31:0] src_val, cmd_data;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_lsb, cmd_msb;

    logic        v_cmd_ready, v_rsp_valid, v_rsp_err, v_fa;
    logic [31:0] v_rsp_data, v_rsp_mask, v_value;
    logic        n_cmd_ready, n_rsp_valid, n_rsp_err, n_fa;
    logic [31:0] n_rsp_data, n_rsp_mask, n_value;
    logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_fa;
    logic [23:0] o_rsp_data, o_rsp_mask, o_value;

    force_release_target #(.WIDTH(32), .IS_NET(1'b0)) u_var (
        .clk(clk), .rst(rst), .src_we(src_we), .src_val(src_val),
        .cmd_valid(cmd_valid), .cmd_ready(v_cmd_ready), .cmd_op(cmd_op),
        .cmd_lsb(cmd_lsb), .cmd_msb(cmd_msb), .cmd_data(cmd_data),
        .rsp_valid(v_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(v_rsp_data),
        .rsp_mask(v_rsp_mask), .rsp_err(v_rsp_err), .value_out(v_value), .force_active(v_fa));

    force_release_target #(.WIDTH(32), .IS_NET(1'b1)) u_net (
        .clk(clk), .rst(rst), .src_we(src_we), .src_val(src_val),
        .cmd_valid(cmd_valid), .cmd_ready(n_cmd_ready), .cmd_op(cmd_op),
        .cmd_lsb(cmd_lsb), .cmd_msb(cmd_msb), .cmd_data(cmd_data),
        .rsp_valid(n_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(n_rsp_data),
        .rsp_mask(n_rsp_mask), .rsp_err(n_rsp_err), .value_out(n_value), .force_active(n_fa));

    force_release_target #(.WIDTH(24), .IS_NET(1'b0)) u_odd (
        .clk(clk), .rst(rst), .src_we(src_we), .src_val(src_val[23:0]),
        .cmd_valid(cmd_valid), .cmd_ready(o_cmd_ready), .cmd_op(cmd_op),
        .cmd_lsb(cmd_lsb), .cmd_msb(cmd_msb), .cmd_data(cmd_data[23:0]),
        .rsp_valid(o_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(o_rsp_data),
        .rsp_mask(o_rsp_mask), .rsp_err(o_rsp_err), .value_out(o_value), .force_active(o_fa));

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {logic [31:0] data; logic [31:0] mask; logic err;} rsp_t;
    rsp_t sbq[$];

    always @(negedge clk) begin
        rsp_t e;
        if (rst) sbq.delete();
        else if (v_rsp_valid && rsp_ready && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_rsp_data", v_rsp_data, e.data);
            chk("sb_rsp_mask", v_rsp_mask, e.mask);
            chk("sb_rsp_err", {31'd0, v_rsp_err}, {31'd0, e.err});
        end
    end

    task automatic src_wr(input logic [31:0] v);
        src_we = 1'b1; src_val = v;
        @(posedge clk); #1;
        src_we = 1'b0;
    endtask

    // Issue one command and return with the DUT in RESP (response not yet acknowledged).
    task automatic do_cmd(input logic [1:0] op, input logic [4:0] lsb, input logic [4:0] msb,
                          input logic [31:0] data, input logic awe, input logic [31:0] aval);
        cmd_op = op; cmd_lsb = lsb; cmd_msb = msb; cmd_data = data; cmd_valid = 1'b1;
        for (int n = 0; n < 8 && !v_cmd_ready; n++) begin @(posedge clk); #1; end
        if (!v_cmd_ready) begin checks++; failures++; $display("FAIL cmd_accept timeout"); end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (awe) begin src_we = 1'b1; src_val = aval; end
        @(posedge clk); #1;
        src_we = 1'b0;
        for (int n = 0; n < 8 && !v_rsp_valid; n++) begin @(posedge clk); #1; end
        if (!v_rsp_valid) begin checks++; failures++; $display("FAIL rsp_valid timeout"); end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic pre_we; logic [31:0] pre_val;
        logic [1:0] op; logic [4:0] lsb; logic [4:0] msb; logic [31:0] data;
        logic awe; logic [31:0] aval;
        logic [31:0] exp_val; logic [31:0] exp_mask; logic exp_err;
    } vec_t;
    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 32'hAAAAAAAA, 2'b01, 5'd0,  5'd31, 32'h55555555, 1'b0, 32'h0, 32'h55555555, 32'hFFFFFFFF, 1'b0};
        tbl[1]  = '{1'b1, 32'h12345678, 2'b11, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0, 32'h55555555, 32'hFFFFFFFF, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,        2'b10, 5'd0,  5'd31, 32'h0,        1'b0, 32'h0, 32'h55555555, 32'h00000000, 1'b0};
        tbl[3]  = '{1'b1, 32'hAAAAAAAA, 2'b11, 5'd0,  5'd0,  32'h0,        1'b0, 32'h0, 32'hAAAAAAAA, 32'h00000000, 1'b0};
        tbl[4]  = '{1'b0, 32'h0,        2'b01, 5'd0,  5'd15, 32'h5555,     1'b0, 32'h0, 32'hAAAA5555, 32'h0000FFFF, 1'b0};
        tbl[5]  = '{1'b0, 32'h0,        2'b01, 5'd28, 5'd31, 32'h3,        1'b0, 32'h0, 32'h3AAA5555, 32'hF000FFFF, 1'b0};
        tbl[6]  = '{1'b0, 32'h0,        2'b01, 5'd4,  5'd7,  32'hF,        1'b0, 32'h0, 32'h3AAA55F5, 32'hF000FFFF, 1'b0};
        tbl[7]  = '{1'b0, 32'h0,        2'b10, 5'd16, 5'd23, 32'h0,        1'b0, 32'h0, 32'h3AAA55F5, 32'hF000FFFF, 1'b0};
        tbl[8]  = '{1'b0, 32'h0,        2'b10, 5'd0,  5'd15, 32'h0,        1'b1, 32'hAAAAAAAA, 32'h3AAAAAAA, 32'hF0000000, 1'b0};
        tbl[9]  = '{1'b0, 32'h0,        2'b01, 5'd8,  5'd4,  32'hFF,       1'b0, 32'h0, 32'h3AAAAAAA, 32'hF0000000, 1'b1};
        tbl[10] = '{1'b0, 32'h0,        2'b00, 5'd0,  5'd3,  32'hF,        1'b0, 32'h0, 32'h3AAAAAAA, 32'hF0000000, 1'b1};
        tbl[11] = '{1'b0, 32'h0,        2'b01, 5'd0,  5'd31, 32'h55555555, 1'b1, 32'h12345678, 32'h55555555, 32'hFFFFFFFF, 1'b0};
        tbl[12] = '{1'b0, 32'h0,        2'b10, 5'd0,  5'd31, 32'h0,        1'b0, 32'h0, 32'h55555555, 32'h00000000, 1'b0};

        rst = 1'b1; src_we = 1'b0; src_val = '0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_op = '0; cmd_lsb = '0; cmd_msb = '0; cmd_data = '0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        chk("reset_cmd_ready", {31'd0, v_cmd_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, v_rsp_valid}, 32'd0);
        chk("reset_value", v_value, 32'h0);
        chk("reset_force_active", {31'd0, v_fa}, 32'd0);
        chk("reset_rsp_data", v_rsp_data, 32'h0);

        for (int i = 0; i < 13; i++) begin
            if (tbl[i].pre_we) src_wr(tbl[i].pre_val);
            sbq.push_back('{tbl[i].exp_val, tbl[i].exp_mask, tbl[i].exp_err});
            do_cmd(tbl[i].op, tbl[i].lsb, tbl[i].msb, tbl[i].data, tbl[i].awe, tbl[i].aval);
            chk($sformatf("vec%0d_value", i), v_value, tbl[i].exp_val);
            chk($sformatf("vec%0d_force_active", i), {31'd0, v_fa}, {31'd0, tbl[i].exp_mask != 0});
            ack();
        end
        chk("sb_drained", sbq.size(), 32'd0);

        // Net vs variable release with a source that is not being written.
        src_val = 32'hAAAAAAAA;
        do_cmd(2'b01, 5'd0, 5'd31, 32'h55555555, 1'b0, 32'h0);
        chk("net_forced", n_value, 32'h55555555);
        ack();
        do_cmd(2'b10, 5'd0, 5'd31, 32'h0, 1'b0, 32'h0);
        chk("net_released", n_value, 32'hAAAAAAAA);
        chk("net_force_active", {31'd0, n_fa}, 32'd0);
        chk("var_released_holds", v_value, 32'h55555555);
        ack();

        // Backpressure: response held, a new command waits for IDLE.
        do_cmd(2'b11, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0);
        cmd_op = 2'b01; cmd_lsb = 5'd0; cmd_msb = 5'd3; cmd_data = 32'hA; cmd_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", {31'd0, v_rsp_valid}, 32'd1);
            chk("bp_rsp_data", v_rsp_data, 32'h55555555);
            chk("bp_rsp_mask", v_rsp_mask, 32'h0);
            chk("bp_cmd_ready", {31'd0, v_cmd_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("bp_idle_ready", {31'd0, v_cmd_ready}, 32'd1);
        chk("bp_not_applied", v_value, 32'h55555555);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_late_rsp_valid", {31'd0, v_rsp_valid}, 32'd1);
        chk("bp_late_value", v_value, 32'h5555555A);
        chk("bp_late_mask", v_rsp_mask, 32'h0000000F);
        ack();

        // Reset while a response is pending.
        do_cmd(2'b01, 5'd0, 5'd31, 32'h55555555, 1'b0, 32'h0);
        chk("rst_pre_value", v_value, 32'h55555555);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rsp_valid", {31'd0, v_rsp_valid}, 32'd0);
        chk("rst_value", v_value, 32'h0);
        chk("rst_force_active", {31'd0, v_fa}, 32'd0);
        chk("rst_cmd_ready", {31'd0, v_cmd_ready}, 32'd1);

        // Out-of-range msb and full-width boundary on the 24-bit instance.
        do_cmd(2'b01, 5'd0, 5'd30, 32'h0, 1'b0, 32'h0);
        chk("odd_msb_err", {31'd0, o_rsp_err}, 32'd1);
        chk("odd_msb_mask", {8'd0, o_rsp_mask}, 32'h0);
        chk("wide_msb30_ok", {31'd0, v_rsp_err}, 32'd0);
        ack();
        do_cmd(2'b01, 5'd0, 5'd23, 32'h00FFFFFF, 1'b0, 32'h0);
        chk("odd_full_err", {31'd0, o_rsp_err}, 32'd0);
        chk("odd_full_mask", {8'd0, o_rsp_mask}, 32'h00FFFFFF);
        chk("odd_full_value", {8'd0, o_value}, 32'h00FFFFFF);
        ack();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
